// File: rtl/dcache_wt_param.sv
`timescale 1ns/1ps
// dcache_wt_param: direct-mapped write-through data cache with line refill.
// Define DCACHE_STATS_EN to add saturating hit/miss counters.
module dcache_wt_param #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int NUM_SETS       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [1:0]            req_dataType,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_wstrb,
   input  logic                  mem_rvalid,
   input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]           stat_hits,
   output logic [31:0]           stat_misses
`endif
);

   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W - 2;
   localparam int WA_W  = ADDR_WIDTH - 2;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      REFILL_REQ,
      REFILL_WAIT,
      WRITE_MEM,
      RESP
   } state_t;

   state_t                state;
   logic [WA_W-1:0]       waddr_q;
   logic                  we_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [3:0]            strb_q;
   logic [OFF_W-1:0]      cnt;
   logic [OFF_W-1:0]      cnt_nxt;
   logic [NUM_SETS-1:0]   valid_q;
   logic [TAG_W-1:0]      tag_q  [NUM_SETS];
   logic [DATA_WIDTH-1:0] data_q [NUM_SETS*WORDS_PER_LINE];

   logic [TAG_W-1:0]      tag_a;
   logic [IDX_W-1:0]      idx_a;
   logic [OFF_W-1:0]      off_a;
   logic                  hit;
   logic [DATA_WIDTH-1:0] line_word;
   logic [DATA_WIDTH-1:0] merged;
   logic                  is_byte;
   logic                  is_half;
   logic [3:0]            lane_strb;
   logic [DATA_WIDTH-1:0] lane_data;

   assign tag_a     = waddr_q[WA_W-1 -: TAG_W];
   assign idx_a     = waddr_q[OFF_W +: IDX_W];
   assign off_a     = waddr_q[OFF_W-1:0];
   assign hit       = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
   assign line_word = data_q[{idx_a, off_a}];
   assign cnt_nxt   = cnt + OFF_W'(1);
   assign is_byte   = req_dataType == 2'b01;
   assign is_half   = req_dataType == 2'b10;

   // Store data is replicated across lanes so the strobe alone selects bytes.
   always_comb begin
      lane_strb = 4'b1111;
      lane_data = req_wdata;
      unique case (1'b1)
         is_byte: begin
            lane_strb = 4'b0001 << req_addr[1:0];
            lane_data = {4{req_wdata[7:0]}};
         end
         is_half: begin
            lane_strb = 4'b0011 << {req_addr[1], 1'b0};
            lane_data = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      merged = line_word;
      for (int b = 0; b < 4; b++) begin
         if (strb_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
      end
   end

   // Line storage carries no reset; the valid bits alone qualify it.
   always_ff @(posedge clk) begin
      if (state == REFILL_WAIT && mem_rvalid) begin
         data_q[{idx_a, cnt}] <= mem_rdata;
         if (&cnt) tag_q[idx_a] <= tag_a;
      end else if (state == LOOKUP && we_q && hit) begin
         data_q[{idx_a, off_a}] <= merged;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         mem_req_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_wstrb     <= '0;
         waddr_q       <= '0;
         we_q          <= 1'b0;
         wdata_q       <= '0;
         strb_q        <= '0;
         cnt           <= '0;
         valid_q       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  waddr_q   <= req_addr[ADDR_WIDTH-1:2];
                  we_q      <= req_we;
                  wdata_q   <= lane_data;
                  strb_q    <= lane_strb;
                  req_ready <= 1'b0;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (we_q) begin
                  mem_req_valid <= 1'b1;
                  mem_we        <= 1'b1;
                  mem_addr      <= {waddr_q, 2'b00};
                  mem_wdata     <= wdata_q;
                  mem_wstrb     <= strb_q;
                  state         <= WRITE_MEM;
               end else if (hit) begin
                  resp_rdata <= line_word;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  // Invalidate first so an aborted refill leaves no stale line.
                  cnt            <= '0;
                  valid_q[idx_a] <= 1'b0;
                  mem_req_valid  <= 1'b1;
                  mem_we         <= 1'b0;
                  mem_wstrb      <= '0;
                  mem_addr       <= {tag_a, idx_a, {OFF_W{1'b0}}, 2'b00};
                  state          <= REFILL_REQ;
               end
            end
            REFILL_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= REFILL_WAIT;
               end
            end
            REFILL_WAIT: begin
               if (mem_rvalid) begin
                  if (&cnt) begin
                     valid_q[idx_a] <= 1'b1;
                     resp_rdata     <= (off_a == cnt) ? mem_rdata : line_word;
                     resp_valid     <= 1'b1;
                     state          <= RESP;
                  end else begin
                     cnt           <= cnt_nxt;
                     mem_req_valid <= 1'b1;
                     mem_addr      <= {tag_a, idx_a, cnt_nxt, 2'b00};
                     state         <= REFILL_REQ;
                  end
               end
            end
            WRITE_MEM: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  mem_we        <= 1'b0;
                  resp_valid    <= 1'b1;
                  state         <= RESP;
               end
            end
            RESP: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_hits   <= '0;
         stat_misses <= '0;
      end else if (state == LOOKUP) begin
         if (hit) begin
            if (~&stat_hits) stat_hits <= stat_hits + 32'd1;
         end else begin
            if (~&stat_misses) stat_misses <= stat_misses + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_wt_param.sv
`timescale 1ns/1ps
// tb_dcache_wt_param: directed checks of refill, hits, merged stores
// and reset during refill against a variable-latency memory model.
module tb_dcache_wt_param;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [1:0]  req_dataType = 2'b00;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b1;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
`ifdef DCACHE_STATS_EN
   logic [31:0] stat_hits;
   logic [31:0] stat_misses;
`endif

   always #5 clk = ~clk;

   dcache_wt_param dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_dataType  (req_dataType),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_wstrb     (mem_wstrb),
      .mem_rvalid    (mem_rvalid),
      .mem_rdata     (mem_rdata)
`ifdef DCACHE_STATS_EN
      ,
      .stat_hits     (stat_hits),
      .stat_misses   (stat_misses)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Memory model: written words in mem, untouched words from init_word.
   logic [31:0] mem [int unsigned];
   logic [31:0] rd_log [$];
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          rd_delay = 0;
   int          stall_ctr = 0;
   logic        stall_en = 1'b0;
   logic [31:0] rd_addr = '0;
   logic [31:0] w_addr = '0;
   logic [31:0] w_data = '0;
   logic [3:0]  w_strb = '0;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      case (a)
         32'h100: return 32'h1111_1111;
         32'h104: return 32'h2222_2222;
         32'h108: return 32'h3333_3333;
         32'h10C: return 32'h4444_4444;
         default: return {16'hCAFE, a[15:0]};
      endcase
   endfunction

   function automatic logic [31:0] rd_word(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : init_word(a);
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         rd_delay      = 0;
         stall_ctr     = 0;
         mem_rvalid    = 1'b0;
         mem_req_ready = 1'b1;
      end else begin
         logic [31:0] wv;
         mem_rvalid = 1'b0;
         if (rd_delay > 0) begin
            rd_delay--;
            if (rd_delay == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = rd_word(rd_addr);
            end
         end
         if (!mem_req_valid) stall_ctr = 0;
         if (mem_req_valid && stall_en && stall_ctr < 3) begin
            mem_req_ready = 1'b0;
            stall_ctr++;
         end else begin
            mem_req_ready = 1'b1;
            if (mem_req_valid && mem_we) begin
               wv = rd_word(mem_addr);
               for (int b = 0; b < 4; b++)
                  if (mem_wstrb[b]) wv[8*b +: 8] = mem_wdata[8*b +: 8];
               mem[mem_addr] = wv;
               w_addr = mem_addr;
               w_data = mem_wdata;
               w_strb = mem_wstrb;
               wr_cnt++;
            end else if (mem_req_valid) begin
               rd_addr  = mem_addr;
               rd_delay = 2;
               rd_log.push_back(mem_addr);
               rd_cnt++;
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] dt,
                         output logic [31:0] rd, output int lat);
      int n;
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_addr     = addr;
      req_wdata    = wd;
      req_dataType = dt;
      n = 0;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      rd = '0;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      req_valid = 1'b0;
      while (!resp_valid && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      if (resp_valid) begin
         rd = resp_rdata;
         @(negedge clk);
         check("resp_one_cycle", 32'(resp_valid), 32'd0);
         check("ready_after_resp", 32'(req_ready), 32'd1);
      end else begin
         check("resp_timeout", 32'(lat), 32'd0);
      end
   endtask

   task automatic expect_refill(input string tag, input int base,
                                input logic [31:0] line);
      check({tag, "_nreads"}, 32'(rd_log.size() - base), 32'd4);
      if (rd_log.size() - base == 4)
         for (int i = 0; i < 4; i++)
            check({tag, "_raddr"}, rd_log[base+i], line + 32'(4*i));
   endtask

   initial begin
      logic [31:0] rd;
      int lat, rb, wb, n;

      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
      rst_n = 1'b1;

      rb = rd_log.size();
      do_req(1'b0, 32'h104, '0, 2'b00, rd, lat);
      check("cold_rdata", rd, 32'h2222_2222);
      check("cold_lat", 32'(lat), 32'd14);
      expect_refill("cold", rb, 32'h100);

      rb = rd_cnt; wb = wr_cnt;
      do_req(1'b0, 32'h10C, '0, 2'b00, rd, lat);
      check("hit_rdata", rd, 32'h4444_4444);
      check("hit_lat", 32'(lat), 32'd2);
      check("hit_no_mem", 32'(rd_cnt - rb + wr_cnt - wb), 32'd0);

      rb = rd_cnt; wb = wr_cnt;
      do_req(1'b1, 32'h106, 32'h0000_00AB, 2'b01, rd, lat);
      check("sb_nwrites", 32'(wr_cnt - wb), 32'd1);
      check("sb_nreads", 32'(rd_cnt - rb), 32'd0);
      check("sb_addr", w_addr, 32'h104);
      check("sb_strb", 32'(w_strb), 32'h4);
      check("sb_wdata", w_data, 32'hABAB_ABAB);
      check("sb_lat", 32'(lat), 32'd3);
      do_req(1'b0, 32'h104, '0, 2'b00, rd, lat);
      check("sb_merge", rd, 32'h22AB_2222);
      check("sb_merge_lat", 32'(lat), 32'd2);

      do_req(1'b1, 32'h10E, 32'h0000_1234, 2'b10, rd, lat);
      check("sh_addr", w_addr, 32'h10C);
      check("sh_strb", 32'(w_strb), 32'hC);
      check("sh_wdata", w_data, 32'h1234_1234);
      do_req(1'b0, 32'h10C, '0, 2'b00, rd, lat);
      check("sh_merge", rd, 32'h1234_4444);

      stall_en = 1'b1;
      rb = rd_cnt; wb = wr_cnt;
      do_req(1'b1, 32'h2000, 32'hDEAD_BEEF, 2'b00, rd, lat);
      stall_en = 1'b0;
      check("sw_miss_nwrites", 32'(wr_cnt - wb), 32'd1);
      check("sw_miss_nreads", 32'(rd_cnt - rb), 32'd0);
      check("sw_miss_addr", w_addr, 32'h2000);
      check("sw_miss_strb", 32'(w_strb), 32'hF);
      check("sw_miss_wdata", w_data, 32'hDEAD_BEEF);
      check("sw_stall_lat", 32'(lat), 32'd6);
      rb = rd_cnt;
      do_req(1'b0, 32'h10C, '0, 2'b00, rd, lat);
      check("no_alloc_hit", rd, 32'h1234_4444);
      check("no_alloc_nreads", 32'(rd_cnt - rb), 32'd0);
      rb = rd_log.size();
      do_req(1'b0, 32'h2000, '0, 2'b00, rd, lat);
      check("ld2000_rdata", rd, 32'hDEAD_BEEF);
      expect_refill("ld2000", rb, 32'h2000);

      rb = rd_log.size();
      do_req(1'b0, 32'h500, '0, 2'b00, rd, lat);
      check("conf500_rdata", rd, 32'hCAFE_0500);
      expect_refill("conf500", rb, 32'h500);
      rb = rd_log.size();
      do_req(1'b0, 32'h100, '0, 2'b00, rd, lat);
      check("conf100_rdata", rd, 32'h1111_1111);
      expect_refill("conf100", rb, 32'h100);
      do_req(1'b0, 32'h104, '0, 2'b00, rd, lat);
      check("conf104_hit", rd, 32'h22AB_2222);
      check("conf104_lat", 32'(lat), 32'd2);

      do_req(1'b1, 32'h10B, 32'h0BAD_F00D, 2'b11, rd, lat);
      check("sres_addr", w_addr, 32'h108);
      check("sres_strb", 32'(w_strb), 32'hF);
      do_req(1'b0, 32'h108, '0, 2'b00, rd, lat);
      check("sres_rdata", rd, 32'h0BAD_F00D);

      rb = rd_log.size();
      do_req(1'b0, 32'h0F4, '0, 2'b00, rd, lat);
      check("set15_rdata", rd, 32'hCAFE_00F4);
      expect_refill("set15", rb, 32'h0F0);
      do_req(1'b0, 32'h100, '0, 2'b00, rd, lat);
      check("set0_after_wrap", rd, 32'h1111_1111);
      check("set0_wrap_lat", 32'(lat), 32'd2);

      // Abort a refill of 0x500 once its third word request is issued.
      rb = rd_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h500;
      req_dataType = 2'b00;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (rd_cnt - rb < 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("abort_third_req", 32'(rd_cnt - rb), 32'd3);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_resp_valid", 32'(resp_valid), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      check("abort_mem_req", 32'(mem_req_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp_valid || !req_ready) n++;
      end
      check("post_abort_idle", 32'(n), 32'd0);
      rb = rd_log.size();
      do_req(1'b0, 32'h104, '0, 2'b00, rd, lat);
      check("reload104_rdata", rd, 32'h22AB_2222);
      expect_refill("reload104", rb, 32'h100);
      rb = rd_log.size();
      do_req(1'b0, 32'h500, '0, 2'b00, rd, lat);
      check("reload500_rdata", rd, 32'hCAFE_0500);
      expect_refill("reload500", rb, 32'h500);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
